// File: rtl/regfile_scoreboard_if.sv
// Read-port interface for the register file: decode drives addr, the register
// file returns the (possibly bypassed) operand value on val.
interface regfile_read_if #(
    parameter int XLEN = 32
);
    logic [4:0]      addr;
    logic [XLEN-1:0] val;

    modport Server (input addr, output val);
    modport Client (output addr, input val);
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register busy scoreboard, two
// combinational read ports with writeback bypass, and a sticky protocol error.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    regfile_read_if.Server    read0,
    regfile_read_if.Server    read1,
    output logic              busy0,
    output logic              busy1,
    input  logic              wr_valid,
    input  logic [4:0]        wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              rsv_valid,
    input  logic [4:0]        rsv_addr,
    input  logic              flush,
    output logic [5:0]        busy_count,
    output logic              err
);

    // Addresses at or beyond NREGS are treated as nonexistent registers.
    function automatic logic in_range(input logic [4:0] a);
        return ({1'b0, a} < 6'(NREGS));
    endfunction

    function automatic logic [5:0] popcount(input logic [NREGS-1:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    logic [XLEN-1:0]  data_q [NREGS];
    logic [XLEN-1:0]  data_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [5:0]       busy_count_q;
    logic [5:0]       busy_count_d;
    logic             err_q;
    logic             err_d;

    logic             wr_en_s;
    logic             rsv_en_s;
    logic             rsv_conflict_s;
    logic             wr_unreserved_s;

    // Qualify write and reserve requests; x0 and out-of-range targets are ignored.
    always_comb begin
        wr_en_s  = wr_valid  && (wr_addr  != 5'd0) && in_range(wr_addr);
        rsv_en_s = rsv_valid && (rsv_addr != 5'd0) && in_range(rsv_addr);
    end

    // Read port 0: bypass a same-cycle write, since that value is available now.
    always_comb begin
        read0.val = {XLEN{1'b0}};
        busy0     = 1'b0;
        if (wr_en_s && (wr_addr == read0.addr)) begin
            read0.val = wr_data;
            busy0     = 1'b0;
        end else if (in_range(read0.addr)) begin
            read0.val = data_q[read0.addr];
            busy0     = busy_q[read0.addr];
        end else begin
            read0.val = {XLEN{1'b0}};
            busy0     = 1'b0;
        end
    end

    // Read port 1: identical to port 0 and fully independent of it.
    always_comb begin
        read1.val = {XLEN{1'b0}};
        busy1     = 1'b0;
        if (wr_en_s && (wr_addr == read1.addr)) begin
            read1.val = wr_data;
            busy1     = 1'b0;
        end else if (in_range(read1.addr)) begin
            read1.val = data_q[read1.addr];
            busy1     = busy_q[read1.addr];
        end else begin
            read1.val = {XLEN{1'b0}};
            busy1     = 1'b0;
        end
    end

    // Next data and busy state; flush beats reserve, reserve beats write-clear.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            data_d[i] = data_q[i];
            busy_d[i] = busy_q[i];
            if (i == 0) begin
                data_d[i] = {XLEN{1'b0}};
                busy_d[i] = 1'b0;
            end else begin
                if (wr_en_s && (wr_addr == 5'(i))) begin
                    data_d[i] = wr_data;
                end else begin
                    data_d[i] = data_q[i];
                end
                if (flush) begin
                    busy_d[i] = 1'b0;
                end else if (rsv_en_s && (rsv_addr == 5'(i))) begin
                    busy_d[i] = 1'b1;
                end else if (wr_en_s && (wr_addr == 5'(i))) begin
                    busy_d[i] = 1'b0;
                end else begin
                    busy_d[i] = busy_q[i];
                end
            end
        end
        busy_count_d = popcount(busy_d);
    end

    // Protocol checks: double reservation, or writeback to an unreserved register.
    always_comb begin
        rsv_conflict_s  = rsv_en_s && !flush && busy_q[rsv_addr] &&
                          !(wr_en_s && (wr_addr == rsv_addr));
        wr_unreserved_s = wr_en_s && !busy_q[wr_addr];
        if (rsv_conflict_s || wr_unreserved_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous reset overriding every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                data_q[i] <= {XLEN{1'b0}};
            end
            busy_q       <= {NREGS{1'b0}};
            busy_count_q <= 6'd0;
            err_q        <= 1'b0;
        end else begin
            data_q       <= data_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            err_q        <= err_d;
        end
    end

    assign busy_count = busy_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard plus a few hand-written
// multi-cycle sequences (full scoreboard, sticky error, reset recovery).
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        busy0, busy1;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [5:0]  busy_count;
    logic        err;

    regfile_read_if #(.XLEN(32)) rd0_if ();
    regfile_read_if #(.XLEN(32)) rd1_if ();

    regfile_scoreboard #(.XLEN(32), .NREGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .read0      (rd0_if),
        .read1      (rd1_if),
        .busy0      (busy0),
        .busy1      (busy1),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .flush      (flush),
        .busy_count (busy_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  a0, a1;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rv;
        logic [4:0]  ra;
        logic        fl;
        logic        chk;
        logic [31:0] v0, v1;
        logic        b0, b1;
        logic [5:0]  bc;
        logic        er;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic r, input logic [4:0] a0, input logic [4:0] a1,
                       input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [4:0] ra, input logic fl,
                       input logic chk, input logic [31:0] v0, input logic [31:0] v1,
                       input logic b0, input logic b1, input logic [5:0] bc, input logic er);
        vec_t v;
        v.rst = r;  v.a0 = a0; v.a1 = a1; v.wv = wv; v.wa = wa; v.wd = wd;
        v.rv = rv;  v.ra = ra; v.fl = fl; v.chk = chk; v.v0 = v0; v.v1 = v1;
        v.b0 = b0;  v.b1 = b1; v.bc = bc; v.er = er;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] a0, input logic [4:0] a1,
                         input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rv, input logic [4:0] ra, input logic fl);
        rst = r; rd0_if.addr = a0; rd1_if.addr = a1;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rsv_valid = rv; rsv_addr = ra; flush = fl;
    endtask

    initial begin
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);

        //   rst   a0     a1     wv    wa     wd             rv    ra     fl    chk   v0             v1             b0    b1    bc     er
        add(1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd5,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd7,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd7,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd7,  5'd0,  1'b1, 5'd7,  32'hDEADBEEF,  1'b0, 5'd0,  1'b0, 1'b1, 32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'hDEADBEEF,  32'hDEADBEEF,  1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd3,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd3,  5'd3,  1'b1, 5'd3,  32'h11,        1'b1, 5'd3,  1'b0, 1'b1, 32'h11,        32'h11,        1'b0, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd3,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h11,        32'h0,         1'b1, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd0,  5'd3,  1'b1, 5'd3,  32'h22,        1'b0, 5'd0,  1'b0, 1'b1, 32'h0,         32'h22,        1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0,         1'b1, 5'd1,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0,         1'b1, 5'd2,  1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 6'd2,  1'b0);
        add(1'b0, 5'd2,  5'd4,  1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 6'd3,  1'b0);
        add(1'b0, 5'd4,  5'd9,  1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  1'b1, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd9,  5'd1,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd0,  5'd0,  1'b1, 5'd0,  32'h55,        1'b1, 5'd0,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd7,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b0, 1'b1, 32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd7,  5'd8,  1'b1, 5'd7,  32'hCAFEF00D,  1'b1, 5'd8,  1'b1, 1'b1, 32'hCAFEF00D,  32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd7,  5'd8,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'hCAFEF00D,  32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd12, 5'd0,  1'b1, 5'd12, 32'h12,        1'b0, 5'd0,  1'b0, 1'b1, 32'h12,        32'h0,         1'b0, 1'b0, 6'd0,  1'b1);
        add(1'b0, 5'd12, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h12,        32'h0,         1'b0, 1'b0, 6'd0,  1'b1);
        add(1'b0, 5'd5,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd1,  1'b1);
        add(1'b1, 5'd7,  5'd0,  1'b1, 5'd6,  32'h66,        1'b1, 5'd6,  1'b1, 1'b1, 32'hCAFEF00D,  32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd6,  5'd7,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd10, 5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 6'd1,  1'b1);
        add(1'b1, 5'd10, 5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd10, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0,  1'b0);
        add(1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 6'd1,  1'b0);
        add(1'b0, 5'd31, 5'd31, 1'b1, 5'd31, 32'hFFFFFFFF,  1'b0, 5'd0,  1'b0, 1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 1'b0, 6'd0,  1'b0);

        for (int s = 0; s < vq.size(); s++) begin
            drive(vq[s].rst, vq[s].a0, vq[s].a1, vq[s].wv, vq[s].wa, vq[s].wd,
                  vq[s].rv, vq[s].ra, vq[s].fl);
            #2;
            if (vq[s].chk) begin
                check("val0",  s, rd0_if.val, vq[s].v0);
                check("val1",  s, rd1_if.val, vq[s].v1);
                check("busy0", s, {31'd0, busy0}, {31'd0, vq[s].b0});
                check("busy1", s, {31'd0, busy1}, {31'd0, vq[s].b1});
            end
            @(posedge clk);
            #1;
            check("busy_count", s, {26'd0, busy_count}, {26'd0, vq[s].bc});
            check("err",        s, {31'd0, err},        {31'd0, vq[s].er});
        end

        // Fill every reservable register; the count must track and top out at 31.
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0);
            @(posedge clk);
            #1;
            check("fill_count", 100 + r, {26'd0, busy_count}, 32'(r));
        end
        drive(1'b0, 5'd31, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        #2;
        check("full_busy0", 200, {31'd0, busy0}, 32'd1);
        check("full_busy1", 200, {31'd0, busy1}, 32'd1);
        check("full_err",   200, {31'd0, err},   32'd0);
        drive(1'b0, 5'd31, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        @(posedge clk);
        #1;
        check("flush_count", 201, {26'd0, busy_count}, 32'd0);
        check("flush_busy0", 201, {31'd0, busy0},      32'd0);

        // Unreserved writeback: err must hold through idle cycles until reset.
        drive(1'b0, 5'd20, 5'd0, 1'b1, 5'd20, 32'h00A5A5A5, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd20, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("sticky_err", 300 + k, {31'd0, err}, 32'd1);
            @(posedge clk);
            #1;
        end
        check("x20_data", 310, rd0_if.val, 32'h00A5A5A5);
        drive(1'b1, 5'd20, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd20, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("rst_err",  311, {31'd0, err}, 32'd0);
        check("rst_data", 311, rd0_if.val,   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width.
REQ-002 The block SHALL have parameter NREGS, default 32, architectural register count, including x0.
REQ-003 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-004 Port clk, input, 1: clock; all state updates on posedge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port read0, regfile_read_if.Server: addr input, 5 bits; val output, XLEN bits; serves decode rs1.
REQ-007 Port read1, regfile_read_if.Server: addr input, 5 bits; val output, XLEN bits; serves decode rs2.
REQ-008 Port busy0 / busy1, output, 1 each: operand at read0.addr / read1.addr not yet available.
REQ-009 Port wr_valid, input, 1: writeback write strobe.
REQ-010 Port wr_addr, input, 5: writeback destination.
REQ-011 Port wr_data, input, XLEN: writeback value.
REQ-012 Port rsv_valid, input, 1: issue reserves a destination.
REQ-013 Port rsv_addr, input, 5: destination being reserved.
REQ-014 Port flush, input, 1: squash; clear all reservations.
REQ-015 Port busy_count, output, 6: number of reserved registers.
REQ-016 Port err, output, 1: sticky protocol-violation flag.

Function
REQ-017 Storage SHALL be NREGS x XLEN flops plus one busy bit per register.
REQ-018 x0 SHALL read 0, never be written, never be busy, and ignore reserve requests.
REQ-019 Reads SHALL be combinational, with zero-cycle latency.
REQ-020 Write-to-read bypass: when wr_valid, wr_addr==addr, and addr!=0, val SHALL equal wr_data in the same cycle; otherwise val SHALL equal stored data.
REQ-021 busyN SHALL equal busy[addrN] AND NOT (wr_valid AND wr_addr==addrN), because a bypassed value counts as available.
REQ-022 On posedge with wr_valid and wr_addr!=0, data[wr_addr] SHALL take wr_data and busy[wr_addr] SHALL clear.
REQ-023 On posedge with rsv_valid, rsv_addr!=0, and no flush, busy[rsv_addr] SHALL set.
REQ-024 When a reserve and a write target the same address in the same cycle, the data SHALL update and the busy bit SHALL end set, with the reserve taking priority.
REQ-025 When flush is high, all busy bits SHALL clear next cycle, flush SHALL override any same-cycle reserve, and a same-cycle write SHALL still update data.
REQ-026 busy_count SHALL be a registered popcount of the busy bits, consistent with the busy bits every cycle, ranging 0..NREGS-1.
REQ-027 err SHALL set when a reserve targets a register that is busy and not being written that cycle, without flush.
REQ-028 err SHALL set when a write targets a non-zero register that is not busy.
REQ-029 err SHALL be sticky and SHALL clear only on rst.
REQ-030 Read ports SHALL be independent and SHALL be allowed to address the same register.

Reset
REQ-031 When rst is high at posedge, all data SHALL become 0, all busy bits 0, busy_count 0, and err 0.
REQ-032 rst SHALL take priority over any same-cycle write, reserve, or flush.
REQ-033 rst mid-operation SHALL drop all reservations and SHALL suppress err for that cycle.

Verification
REQ-034 Scenario: reset, then read0.addr=5 and read1.addr=0 -> val 0/0, busy 0/0, busy_count 0.
REQ-035 Scenario: rsv x7; next cycle read0.addr=7 -> busy0=1 and busy_count=1; write x7=0xDEADBEEF the same cycle -> val=0xDEADBEEF and busy0=0 combinationally, then after the edge busy_count=0.
REQ-036 Scenario: reserve x3 and write x3=0x11 in the same cycle (x3 previously reserved) -> data 0x11, busy remains 1, busy_count unchanged, err=0.
REQ-037 Scenario: reserve x1, x2, and x4 on consecutive cycles, then flush together with rsv x9 -> next cycle all busy 0, busy_count 0.
REQ-038 Scenario: write x0=0x55 and rsv x0 -> read x0 gives 0, busy 0, err 0.
REQ-039 Scenario: write x12 while not busy -> err=1 next cycle and stays 1 until rst.
